cpu_control_fsm: RTL and testbench
==================================

Name: cpu_control_fsm

Overview:
Multi-cycle control sequencer for the 8-bit CPU. It drives the fetch of each 16-bit instruction as two 8-bit ROM reads, waits for the instruction decoder to settle, then steps execute, memory and writeback per opcode. It issues every datapath enable: PC, instruction register halves, register file, ALU source and data memory. It also owns halt/resume, the memory-wait timeout and the retired-instruction counter.

Parameters:
MEM_WAIT_MAX, 15, maximum cycles spent in MEM waiting for mem_ready before fault; range 1..255.
CNT_W, 16, width of retired_count.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
instr_Opcode  in  4  opcode from decoder (addi=0 … blt=F, HLT=D).
Is_immediate  in  1  from decoder; passed through to alu_src in EXECUTE.
eq_flag  in  1  ALU A==B result.
lt_flag  in  1  ALU A<B result.
mem_ready  in  1  data memory done (lw data valid / sw accepted).
run  in  1  resume pulse, sampled in HALT only.
pc_write  out  1  load PC this cycle.
pc_src  out  2  00=PC+1, 01=branch target, 10=jmp_addr, 11 unused.
ir_hi_write  out  1  latch ROM byte into IR[15:8].
ir_lo_write  out  1  latch ROM byte into IR[7:0].
alu_src  out  1  1=immediate operand, 0=register 2.
reg_write  out  1  register file write enable.
wb_sel  out  1  1=memory data, 0=ALU result.
mem_read  out  1  data memory read strobe.
mem_write  out  1  data memory write strobe.
halted  out  1  high in HALT.
fault  out  1  sticky memory-timeout flag.
state  out  3  current state encoding, for debug.
retired_count  out  CNT_W  instructions completed.

Behaviour:
- States and encoding: FETCH_HI=0, FETCH_LO=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6. Encoding 7 is illegal and goes to HALT with fault=1.
- Async reset: state=FETCH_HI, fault=0, retired_count=0. All combinational outputs take their values for FETCH_HI.
- Outputs are decoded combinationally from state, opcode and flags. State, fault and count registers update on posedge clk.
- FETCH_HI: ir_hi_write=1, pc_write=1, pc_src=00. Next state FETCH_LO.
- FETCH_LO: ir_lo_write=1, pc_write=1, pc_src=00. Next state DECODE.
- DECODE: all strobes 0. Next state EXECUTE.
- EXECUTE: alu_src=Is_immediate. Next state by opcode:
  - add/addi/sub/subi/slt/slti/sra/sll/NAND (0,1,3,4,7,8,B,C,E) go to WRITEBACK.
  - lw/sw (2,A) go to MEM.
  - beq: pc_write=eq_flag, pc_src=01.
  - bne: pc_write=~eq_flag, pc_src=01.
  - blt: pc_write=lt_flag, pc_src=01.
  - jump: pc_write=1, pc_src=10.
  - Branches and jump go to FETCH_HI, and retired_count increments.
  - HLT goes to HALT, and retired_count increments.
- MEM:
  - Strobes: mem_read=1 for lw, mem_write=1 for sw. The strobe is held every MEM cycle until exit.
  - Wait counter clears on entry and increments each cycle with mem_ready=0.
  - mem_ready=1: lw goes to WRITEBACK; sw goes to FETCH_HI and retired_count increments.
  - Counter reaching MEM_WAIT_MAX with mem_ready still 0: fault set, go to HALT, no count increment.
  - mem_ready=1 in the same cycle the counter hits the limit: success wins.
- WRITEBACK: reg_write=1, wb_sel=1 for lw, else 0. Next state FETCH_HI; retired_count increments.
- HALT:
  - halted=1; all strobes 0.
  - run=1 with fault=0: go to FETCH_HI, and PC continues from HLT+1.
  - run is ignored while fault=1. Only reset clears fault.
- Latency: ALU op 5 cycles; lw 6+N (N = wait cycles); sw 5+N; branch/jump 4; HLT reaches HALT after 4.
- retired_count wraps modulo 2^CNT_W with no saturation.
- Reset asserted mid-instruction: the FSM aborts immediately and no partial write strobe survives. The partially latched IR is don't-care.

Test Plan:
- Reset, then add (0x1250) → FH,FL,DE,EX,WB; reg_write=1 only in cycle 5; pc_write in cycles 1–2; retired_count=1.
- beq with eq_flag=1 → pc_write=1, pc_src=01 in EXECUTE, back at FETCH_HI at cycle 5. Repeat with eq_flag=0 → pc_write=0 in EXECUTE. bne with eq_flag=0 → taken.
- lw with mem_ready delayed 3 cycles → mem_read held 4 cycles, then WRITEBACK with wb_sel=1, reg_write=1; total 9 cycles.
- sw with mem_ready stuck 0, MEM_WAIT_MAX=15 → mem_write held 15 cycles, fault=1, halted=1; run pulse → stays HALT.
- HLT (0xD000) → halted=1 after EXECUTE; retired_count+1; run=1 → FETCH_HI next cycle, pc_write=1.
- rst_n low during MEM of sw → next sampled state FETCH_HI, mem_write=0, count=0; CNT_W=4 with 16 ALU ops → count wraps to 0.

Source files
------------

// File: rtl/cpu_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the 8-bit CPU datapath.
// The master side is the sequencer; the slave side is the datapath/decoder.
interface cpu_control_fsm_if #(
  parameter int CNT_W = 16
);
  // Decoder / ALU / memory status into the sequencer
  logic [3:0]       instr_Opcode;
  logic             Is_immediate;
  logic             eq_flag;
  logic             lt_flag;
  logic             mem_ready;
  logic             run;

  // Datapath enables out of the sequencer
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ir_hi_write;
  logic             ir_lo_write;
  logic             alu_src;
  logic             reg_write;
  logic             wb_sel;
  logic             mem_read;
  logic             mem_write;
  logic             halted;
  logic             fault;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired_count;

  modport master (
    input  instr_Opcode, Is_immediate, eq_flag, lt_flag, mem_ready, run,
    output pc_write, pc_src, ir_hi_write, ir_lo_write, alu_src, reg_write,
           wb_sel, mem_read, mem_write, halted, fault, state, retired_count
  );

  modport slave (
    output instr_Opcode, Is_immediate, eq_flag, lt_flag, mem_ready, run,
    input  pc_write, pc_src, ir_hi_write, ir_lo_write, alu_src, reg_write,
           wb_sel, mem_read, mem_write, halted, fault, state, retired_count
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the 8-bit CPU: two-byte fetch, decode,
// execute, memory and writeback, plus halt/resume, memory timeout and retire count.
module cpu_control_fsm #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  cpu_control_fsm_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH_HI  = 3'd0,
    S_FETCH_LO  = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic [3:0] OP_ADDI = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_SUBI = 4'h4;
  localparam logic [3:0] OP_BEQ  = 4'h5;
  localparam logic [3:0] OP_BNE  = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_SLTI = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_SW   = 4'hA;
  localparam logic [3:0] OP_SRA  = 4'hB;
  localparam logic [3:0] OP_SLL  = 4'hC;
  localparam logic [3:0] OP_HLT  = 4'hD;
  localparam logic [3:0] OP_NAND = 4'hE;
  localparam logic [3:0] OP_BLT  = 4'hF;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Last wait-count value that may still see mem_ready before the timeout fires.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t           state_q;
  state_t           state_d;
  logic             fault_q;
  logic [CNT_W-1:0] retired_q;
  logic [7:0]       wait_cnt_q;

  logic             retire;
  logic             set_fault;
  logic             mem_timeout;

  logic [3:0]       op;
  logic             op_alu;
  logic             op_lw;
  logic             op_sw;

  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ir_hi_write;
  logic             ir_lo_write;
  logic             alu_src;
  logic             reg_write;
  logic             wb_sel;
  logic             mem_read;
  logic             mem_write;
  logic             halted;

  assign op     = bus.instr_Opcode;
  assign op_lw  = (op == OP_LW);
  assign op_sw  = (op == OP_SW);
  assign op_alu = op inside {OP_ADDI, OP_ADD, OP_SUB, OP_SUBI, OP_SLT,
                             OP_SLTI, OP_SRA, OP_SLL, OP_NAND};

  assign mem_timeout = (wait_cnt_q == WAIT_LAST) && !bus.mem_ready;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    pc_src      = PC_INC;
    ir_hi_write = 1'b0;
    ir_lo_write = 1'b0;
    alu_src     = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    halted      = 1'b0;
    retire      = 1'b0;
    set_fault   = 1'b0;

    case (state_q)
      S_FETCH_HI: begin
        ir_hi_write = 1'b1;
        pc_write    = 1'b1;
        state_d     = S_FETCH_LO;
      end

      S_FETCH_LO: begin
        ir_lo_write = 1'b1;
        pc_write    = 1'b1;
        state_d     = S_DECODE;
      end

      S_DECODE: begin
        state_d = S_EXECUTE;
      end

      S_EXECUTE: begin
        alu_src = bus.Is_immediate;
        if (op_alu) begin
          state_d = S_WRITEBACK;
        end else if (op_lw || op_sw) begin
          state_d = S_MEM;
        end else if (op == OP_HLT) begin
          state_d = S_HALT;
          retire  = 1'b1;
        end else begin
          // Remaining opcodes are control transfers; they retire here.
          state_d = S_FETCH_HI;
          retire  = 1'b1;
          if (op == OP_JMP) begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
          end else begin
            pc_src = PC_BRANCH;
            if (op == OP_BEQ)      pc_write = bus.eq_flag;
            else if (op == OP_BNE) pc_write = ~bus.eq_flag;
            else                   pc_write = bus.lt_flag;
          end
        end
      end

      S_MEM: begin
        mem_read  = op_lw;
        mem_write = op_sw;
        // A ready arriving on the final allowed cycle beats the timeout.
        if (bus.mem_ready) begin
          if (op_lw) begin
            state_d = S_WRITEBACK;
          end else begin
            state_d = S_FETCH_HI;
            retire  = 1'b1;
          end
        end else if (mem_timeout) begin
          state_d   = S_HALT;
          set_fault = 1'b1;
        end
      end

      S_WRITEBACK: begin
        reg_write = 1'b1;
        wb_sel    = op_lw;
        state_d   = S_FETCH_HI;
        retire    = 1'b1;
      end

      S_HALT: begin
        halted = 1'b1;
        if (bus.run && !fault_q) state_d = S_FETCH_HI;
      end

      default: begin
        state_d   = S_HALT;
        set_fault = 1'b1;
      end
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH_HI;
      fault_q    <= 1'b0;
      retired_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (set_fault) fault_q <= 1'b1;
      if (retire)    retired_q <= retired_q + CNT_W'(1);
      // Counter idles at zero outside MEM, so it is already clear on entry.
      if (state_q == S_MEM && !bus.mem_ready) wait_cnt_q <= wait_cnt_q + 8'd1;
      else                                    wait_cnt_q <= '0;
    end
  end

  assign bus.pc_write      = pc_write;
  assign bus.pc_src        = pc_src;
  assign bus.ir_hi_write   = ir_hi_write;
  assign bus.ir_lo_write   = ir_lo_write;
  assign bus.alu_src       = alu_src;
  assign bus.reg_write     = reg_write;
  assign bus.wb_sel        = wb_sel;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.halted        = halted;
  assign bus.fault         = fault_q;
  assign bus.state         = state_q;
  assign bus.retired_count = retired_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Randomised bench for cpu_control_fsm: an instruction-level reference model
// queues the expected per-cycle control word, a negedge monitor pops and compares.
module tb_cpu_control_fsm;

  localparam int MAXW = 15;
  localparam int CW   = 4;

  localparam logic [2:0] ST_FH = 3'd0, ST_FL = 3'd1, ST_DE = 3'd2, ST_EX = 3'd3,
                         ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6;

  localparam logic [3:0] OP_ADD = 4'h1, OP_LW = 4'h2, OP_BEQ = 4'h5, OP_BNE = 4'h6,
                         OP_JMP = 4'h9, OP_SW = 4'hA, OP_HLT = 4'hD, OP_BLT = 4'hF;

  typedef struct packed {
    logic [2:0]    st;
    logic          pc_write;
    logic [1:0]    pc_src;
    logic          ir_hi;
    logic          ir_lo;
    logic          alu_src;
    logic          reg_write;
    logic          wb_sel;
    logic          mem_read;
    logic          mem_write;
    logic          halted;
    logic          fault;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpu_control_fsm_if #(.CNT_W(CW)) bus ();

  cpu_control_fsm #(
    .MEM_WAIT_MAX (MAXW),
    .CNT_W        (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned m_count = 0;
  logic        m_fault = 1'b0;
  logic [3:0]  cur_op  = 4'h0;
  logic        cur_imm = 1'b0;
  logic        cur_eq  = 1'b0;
  logic        cur_lt  = 1'b0;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic bit is_alu(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h7, 4'h8, 4'hB, 4'hC, 4'hE};
  endfunction

  // Idle control word for a state, carrying the model's architectural count/fault.
  function automatic exp_t base(input logic [2:0] st);
    exp_t e;
    e        = '0;
    e.st     = st;
    e.halted = (st == ST_HALT);
    e.fault  = m_fault;
    e.cnt    = CW'(m_count % (1 << CW));
    return e;
  endfunction

  task automatic push(input exp_t e, input logic ready, input logic runv, input string tag);
    @(posedge clk);
    #1;
    rst_n            = 1'b1;
    bus.instr_Opcode = cur_op;
    bus.Is_immediate = cur_imm;
    bus.eq_flag      = cur_eq;
    bus.lt_flag      = cur_lt;
    bus.mem_ready    = ready;
    bus.run          = runv;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic do_reset();
    exp_t e;
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.mem_ready = rb();
    bus.run       = rb();
    m_count       = 0;
    m_fault       = 1'b0;
    e             = base(ST_FH);
    e.pc_write    = 1'b1;
    e.ir_hi       = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back("reset");
  endtask

  // One instruction: ready rises after 'delay' MEM cycles; abort_at >= 0 resets mid-MEM.
  task automatic run_instr(input logic [3:0] op, input logic imm, input logic eq,
                           input logic lt, input int delay, input int abort_at);
    exp_t  e;
    string tag;
    logic  rdy;
    cur_op  = op;
    cur_imm = imm;
    cur_eq  = eq;
    cur_lt  = lt;
    tag     = $sformatf("op%h", op);

    e = base(ST_FH); e.pc_write = 1'b1; e.ir_hi = 1'b1; push(e, rb(), rb(), tag);
    e = base(ST_FL); e.pc_write = 1'b1; e.ir_lo = 1'b1; push(e, rb(), rb(), tag);
    e = base(ST_DE); push(e, rb(), rb(), tag);

    e = base(ST_EX);
    e.alu_src = imm;
    case (op)
      OP_BEQ:  begin e.pc_src = 2'b01; e.pc_write = eq;  end
      OP_BNE:  begin e.pc_src = 2'b01; e.pc_write = !eq; end
      OP_BLT:  begin e.pc_src = 2'b01; e.pc_write = lt;  end
      OP_JMP:  begin e.pc_src = 2'b10; e.pc_write = 1'b1; end
      default: ;
    endcase
    push(e, rb(), rb(), tag);

    if (is_alu(op)) begin
      e = base(ST_WB); e.reg_write = 1'b1; push(e, rb(), rb(), tag);
      m_count++;
    end else if (op == OP_LW || op == OP_SW) begin
      for (int i = 0; i < MAXW; i++) begin
        if (i == abort_at) begin
          do_reset();
          return;
        end
        rdy = (i >= delay);
        e = base(ST_MEM);
        e.mem_read  = (op == OP_LW);
        e.mem_write = (op == OP_SW);
        push(e, rdy, rb(), tag);
        if (rdy) begin
          if (op == OP_LW) begin
            e = base(ST_WB); e.reg_write = 1'b1; e.wb_sel = 1'b1; push(e, rb(), rb(), tag);
          end
          m_count++;
          return;
        end
      end
      m_fault = 1'b1;
    end else begin
      m_count++;
    end
  endtask

  // Idle in HALT; a fault-free halt then resumes with a run pulse.
  task automatic halt_seq(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = base(ST_HALT);
      push(e, rb(), m_fault ? 1'(i % 2) : 1'b0, "halt");
    end
    if (!m_fault) begin
      e = base(ST_HALT);
      push(e, rb(), 1'b1, "resume");
    end
  endtask

  always @(negedge clk) begin
    exp_t  e;
    exp_t  a;
    string t;
    if (exp_q.size() > 0) begin
      e           = exp_q.pop_front();
      t           = tag_q.pop_front();
      a.st        = bus.state;
      a.pc_write  = bus.pc_write;
      a.pc_src    = bus.pc_src;
      a.ir_hi     = bus.ir_hi_write;
      a.ir_lo     = bus.ir_lo_write;
      a.alu_src   = bus.alu_src;
      a.reg_write = bus.reg_write;
      a.wb_sel    = bus.wb_sel;
      a.mem_read  = bus.mem_read;
      a.mem_write = bus.mem_write;
      a.halted    = bus.halted;
      a.fault     = bus.fault;
      a.cnt       = bus.retired_count;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s @%0t: got st=%0d word=%b, want st=%0d word=%b",
                 t, $time, a.st, a, e.st, e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] op;
    logic [3:0] alu_ops [9];
    int         delay;
    alu_ops = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h7, 4'h8, 4'hB, 4'hC, 4'hE};

    rst_n            = 1'b0;
    bus.instr_Opcode = 4'h0;
    bus.Is_immediate = 1'b0;
    bus.eq_flag      = 1'b0;
    bus.lt_flag      = 1'b0;
    bus.mem_ready    = 1'b0;
    bus.run          = 1'b0;

    do_reset();
    run_instr(OP_ADD, 1'b0, 1'b0, 1'b0, 0, -1);
    run_instr(OP_BEQ, 1'b0, 1'b1, 1'b0, 0, -1);
    run_instr(OP_BEQ, 1'b0, 1'b0, 1'b0, 0, -1);
    run_instr(OP_BNE, 1'b0, 1'b0, 1'b0, 0, -1);
    run_instr(OP_LW,  1'b1, 1'b0, 1'b0, 3, -1);
    run_instr(OP_HLT, 1'b0, 1'b0, 1'b0, 0, -1);
    halt_seq(2);
    run_instr(OP_SW,  1'b1, 1'b0, 1'b0, MAXW - 1, -1);

    for (int k = 0; k < 150; k++) begin
      op    = 4'($urandom_range(0, 15));
      delay = ($urandom_range(0, 7) == 0) ? MAXW - 1 : $urandom_range(0, 4);
      run_instr(op, rb(), rb(), rb(), delay, -1);
      if (op == OP_HLT) halt_seq($urandom_range(0, 3));
    end

    do_reset();
    for (int k = 0; k < 16; k++)
      run_instr(alu_ops[$urandom_range(0, 8)], rb(), rb(), rb(), 0, -1);

    run_instr(OP_SW, 1'b0, 1'b0, 1'b0, 100, 5);
    run_instr(OP_SW, 1'b0, 1'b0, 1'b0, 100, -1);
    halt_seq(4);
    do_reset();
    run_instr(OP_ADD, 1'b0, 1'b0, 1'b0, 0, -1);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
